// File: rtl/lane_pkg.sv
// Shared sizing helpers and beat-counter type for the lane deserializer.
package lane_pkg;

   localparam int unsigned CNT_MAX_W = 8;

   typedef logic [CNT_MAX_W-1:0] beat_cnt_t;

   function automatic int unsigned beats(input int unsigned width, input int unsigned step);
      return width / step;
   endfunction

   // A single-beat word still needs one counter bit to stay representable.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lane_deserializer_beat_counter.sv
// Modulo-N beat counter with enable, synchronous clear and a registered last flag.
module beat_counter
   import lane_pkg::*;
#(
   parameter int unsigned N  = 10,
   parameter int unsigned CW = cnt_width(N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic          clr_i,
   output logic [CW-1:0] count_o,
   output logic          last_o
);

   logic [CW-1:0] count_q, count_d;
   logic          last_q, last_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = last_q ? '0 : count_q + CW'(1);
      end
      last_d = (count_d == CW'(N - 1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         last_q  <= (N == 1);
      end else begin
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = last_q;

endmodule

// File: rtl/lane_deserializer.sv
// Collects STEP-bit beats into WIDTH-bit words, LSB lane first, and hands
// each completed word off on a valid/ready port.
module lane_deserializer
   import lane_pkg::*;
#(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned STEP  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [STEP-1:0]  i_data,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ready
);

   localparam int unsigned N  = beats(WIDTH, STEP);
   localparam int unsigned CW = cnt_width(N);

   if (!((STEP == 1) || (STEP == 2)) || ((WIDTH % STEP) != 0)) begin : g_illegal
      $error("lane_deserializer: STEP must be 1 or 2 and divide WIDTH");
   end else begin : g_core

      logic [CW-1:0]    count;
      logic             last;
      logic             accept_c;
      logic             load_c;
      logic [WIDTH-1:0] word_c;
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] data_q, data_d;

      // Only the closing beat can stall, and only while the previous word is unclaimed.
      assign o_ready  = !i_flush && !(last && valid_q && !i_ready);
      assign accept_c = i_valid && o_ready;
      assign load_c   = accept_c && last;

      beat_counter #(
         .N  (N),
         .CW (CW)
      ) u_beat_counter (
         .clk_i   (i_clk),
         .rst_i   (i_rst),
         .en_i    (accept_c),
         .clr_i   (i_flush),
         .count_o (count),
         .last_o  (last)
      );

      for (genvar b = 0; b < WIDTH; b += STEP) begin : g_lane
         localparam int unsigned K = b / STEP;
         logic [STEP-1:0] lane_q;

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               lane_q <= '0;
            end else if (accept_c && (count == CW'(K))) begin
               lane_q <= i_data;
            end
         end

         // The lane currently being filled forwards the live beat into the word.
         assign word_c[b +: STEP] = (count == CW'(K)) ? i_data : lane_q;
      end

      always_comb begin
         valid_d = valid_q && !i_ready;
         data_d  = data_q;
         if (load_c) begin
            valid_d = 1'b1;
            data_d  = word_c;
         end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
         end
      end

      assign o_valid = valid_q;
      assign o_data  = data_q;
   end

endmodule

// File: tb/tb_lane_deserializer.sv
// Directed and randomized checks of lane_deserializer at STEP=1 and STEP=2.
module tb_lane_deserializer;

   logic       clk;
   logic       rst;

   logic       flush1, valid1, ready1;
   logic [0:0] data1;
   logic       o_ready1, o_valid1;
   logic [9:0] o_data1;

   logic       flush2, valid2, ready2;
   logic [1:0] data2;
   logic       o_ready2, o_valid2;
   logic [9:0] o_data2;

   int n_checks;
   int n_fail;

   lane_deserializer #(.WIDTH(10), .STEP(1)) dut1 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_flush (flush1),
      .i_valid (valid1),
      .i_data  (data1),
      .o_ready (o_ready1),
      .o_valid (o_valid1),
      .o_data  (o_data1),
      .i_ready (ready1)
   );

   lane_deserializer #(.WIDTH(10), .STEP(2)) dut2 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_flush (flush2),
      .i_valid (valid2),
      .i_data  (data2),
      .o_ready (o_ready2),
      .o_valid (o_valid2),
      .o_data  (o_data2),
      .i_ready (ready2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Send beats 0..nb-1 of w (LSB first) to the STEP=1 instance; each must be accepted.
   task automatic send1(input logic [9:0] w, input int nb);
      for (int i = 0; i < nb; i++) begin
         valid1 = 1'b1;
         data1  = w[i];
         #1;
         check("send1_ready", o_ready1, 1'b1);
         @(posedge clk); #1;
      end
      valid1 = 1'b0;
   endtask

   logic [9:0] wa, wb, cur;
   logic [9:0] m_acc, m_word;
   logic       m_held, exp_rdy;
   int         m_part;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      flush1 = 1'b0; valid1 = 1'b0; data1 = '0; ready1 = 1'b1;
      flush2 = 1'b0; valid2 = 1'b0; data2 = '0; ready2 = 1'b1;
      #1;
      check("rst_valid", o_valid1, 1'b0);
      check("rst_data", o_data1, 10'h000);
      check("rst_ready", o_ready1, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Hold a word, start another, then reset mid-word.
      ready1 = 1'b0;
      send1(10'h34D, 10);
      check("held_valid", o_valid1, 1'b1);
      send1(10'h3FF, 3);
      rst = 1'b1;
      #1;
      check("async_rst_valid", o_valid1, 1'b0);
      check("async_rst_data", o_data1, 10'h000);
      check("async_rst_ready", o_ready1, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic STEP=1 word, valid for exactly one cycle.
      ready1 = 1'b1;
      send1(10'h34D, 10);
      check("basic_valid", o_valid1, 1'b1);
      check("basic_data", o_data1, 10'h34D);
      @(posedge clk); #1;
      check("basic_valid_drop", o_valid1, 1'b0);

      // STEP=2 back-to-back words.
      wa = 10'h239;
      wb = 10'h1E4;
      for (int i = 0; i < 10; i++) begin
         cur    = (i < 5) ? wa : wb;
         valid2 = 1'b1;
         data2  = cur[2*(i%5) +: 2];
         #1;
         check("s2_ready", o_ready2, 1'b1);
         @(posedge clk); #1;
         if (i == 4) begin
            check("s2_w0_valid", o_valid2, 1'b1);
            check("s2_w0_data", o_data2, 10'h239);
         end
         if (i == 5) check("s2_mid_valid", o_valid2, 1'b0);
         if (i == 9) begin
            check("s2_w1_valid", o_valid2, 1'b1);
            check("s2_w1_data", o_data2, 10'h1E4);
         end
      end
      valid2 = 1'b0;
      @(posedge clk); #1;
      check("s2_idle_valid", o_valid2, 1'b0);

      // Backpressure: 0x34D pending, next word's last beat must stall.
      send1(10'h34D, 10);
      ready1 = 1'b0;
      send1(10'h1B6, 9);
      check("bp_hold_data", o_data1, 10'h34D);
      valid1 = 1'b1;
      data1  = 1'b0;
      #1;
      check("bp_last_refused", o_ready1, 1'b0);
      @(posedge clk); #1;
      check("bp_still_valid", o_valid1, 1'b1);
      check("bp_still_data", o_data1, 10'h34D);
      ready1 = 1'b1;
      #1;
      check("bp_release_ready", o_ready1, 1'b1);
      @(posedge clk); #1;
      valid1 = 1'b0;
      check("bp_new_valid", o_valid1, 1'b1);
      check("bp_new_data", o_data1, 10'h1B6);
      @(posedge clk); #1;
      check("bp_drop_valid", o_valid1, 1'b0);

      // Flush after 4 beats discards them.
      send1(10'h3FF, 4);
      flush1 = 1'b1;
      valid1 = 1'b1;
      data1  = 1'b1;
      #1;
      check("flush_ready", o_ready1, 1'b0);
      @(posedge clk); #1;
      flush1 = 1'b0;
      valid1 = 1'b0;
      check("flush_no_valid", o_valid1, 1'b0);
      send1(10'h2AA, 10);
      check("flush_word_valid", o_valid1, 1'b1);
      check("flush_word_data", o_data1, 10'h2AA);

      // Flush together with the last beat: no word, counter back to zero.
      send1(10'h0FF, 9);
      flush1 = 1'b1;
      valid1 = 1'b1;
      data1  = 1'b1;
      #1;
      check("flush_last_ready", o_ready1, 1'b0);
      @(posedge clk); #1;
      flush1 = 1'b0;
      valid1 = 1'b0;
      check("flush_last_no_valid", o_valid1, 1'b0);
      check("flush_last_data_kept", o_data1, 10'h2AA);
      send1(10'h155, 9);
      check("flush_last_no_early", o_valid1, 1'b0);
      send1(10'h155 >> 9, 1);
      check("flush_last_next_valid", o_valid1, 1'b1);
      check("flush_last_next_data", o_data1, 10'h155);

      // Randomized traffic against a beat-counting reference model.
      rst = 1'b1;
      #1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_part = 0;
      m_acc  = '0;
      m_word = '0;
      m_held = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         valid1 = (($urandom % 4) != 0);
         data1  = 1'($urandom);
         ready1 = (($urandom % 3) != 0);
         flush1 = (($urandom % 24) == 0);
         #1;
         exp_rdy = !flush1 && !((m_part == 9) && m_held && !ready1);
         check("rnd_ready", o_ready1, exp_rdy);
         if (m_held && ready1) m_held = 1'b0;
         if (flush1) begin
            m_part = 0;
         end else if (valid1 && exp_rdy) begin
            m_acc[m_part] = data1[0];
            if (m_part == 9) begin
               m_part = 0;
               m_held = 1'b1;
               m_word = m_acc;
            end else begin
               m_part++;
            end
         end
         @(posedge clk); #1;
         check("rnd_valid", o_valid1, m_held);
         check("rnd_data", o_data1, m_word);
      end
      valid1 = 1'b0;
      flush1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lane_deserializer.md
# lane_deserializer

Receive-side counterpart of the lane serializer. Collects a stream of STEP-bit beats into WIDTH-bit words, one per-lane capture register per beat slot, and presents each completed word on a valid/ready output port. Sits between a narrow serial link and word-wide consumer logic. Applies backpressure upstream only when a completed word cannot be handed off.

## Interface
Parameters:
- WIDTH, 10, output word width in bits; must be a multiple of STEP.
- STEP, 1, bits per input beat; legal values are 1 or 2.

Ports (clock and reset first):
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_flush  input  1  synchronous discard of any partial word.
- i_valid  input  1  input beat valid.
- i_data  input  STEP  input beat.
- o_ready  output  1  input beat accepted when i_valid && o_ready.
- o_valid  output  1  completed word available.
- o_data  output  WIDTH  completed word.
- i_ready  input  1  consumer accepts word when o_valid && i_ready.

## Operation
- N = WIDTH/STEP beats per word.
- Beat counter: $clog2(N) bits, values 0..N-1.
- Lane placement: beat k of a word lands in bits [k*STEP +: STEP], LSB lane first.
- One capture register per lane, generated with a for loop of step STEP over 0..WIDTH-1.
- Lane k loads i_data on an accepted beat while count == k.
- Accepted beat with count < N-1: count increments.
- Accepted beat with count == N-1:
  - Count wraps to 0.
  - The full word (lanes 0..N-2 plus the current beat) loads the output register.
  - o_valid sets.
- o_ready = !(count == N-1 && o_valid && !i_ready).
  - The last beat is refused only while the previous word is still held.
  - Lanes 0..N-2 of the next word are always accepted.
- Word handshake: o_valid && i_ready clears o_valid, unless a new word loads in the same cycle.
  - If both happen in the same cycle, o_valid stays 1 and o_data takes the new word.
- o_data is stable while o_valid && !i_ready.
- i_flush:
  - Sets count to 0.
  - Beats presented in the flush cycle are dropped; o_ready is 0 during flush.
  - Has no effect on o_valid or o_data.
- Lane capture registers are not cleared by flush; they are overwritten before reuse.
- STEP legality is checked at elaboration with a generate-if. An illegal STEP produces no logic and reports an elaboration error.

## Timing
- Reset values:
  - o_valid = 0.
  - o_data = 0.
  - o_ready = 1 (count = 0).
  - Count = 0.
  - Lane registers = 0.
- Latency: last beat accepted at edge t gives o_valid = 1 and o_data valid after edge t.
- Throughput: one word every N cycles with continuous i_valid and i_ready.
- o_ready is combinational from count, o_valid and i_ready; there is no path from i_valid or i_data.
- Reset mid-word: the partial word is lost, and outputs return to their reset values asynchronously.
- Flush and last beat in the same cycle: flush wins, no word is produced, and count = 0.

## Structure
- Shared package lane_pkg:
  - Function beats(WIDTH, STEP) returning N.
  - Function cnt_width(N).
  - Typedef for the beat counter.
- One natural sub-module: beat_counter.
  - Behaviour: modulo-N counter with enable and synchronous clear.
  - Outputs: the count and a last flag (count == N-1).
- Lane registers and the output register stay in lane_deserializer as generate blocks.

## Test plan
- Reset: assert i_rst mid-word at STEP=1 → o_valid=0, o_data=0, o_ready=1 immediately. After release, a fresh 10-beat word is assembled correctly.
- Basic STEP=1: beats 1,0,1,1,0,0,1,0,1,1 with i_ready=1 → o_data=10'h34D, and o_valid is high for exactly one cycle, the cycle after the 10th beat.
- STEP=2: beats 2'b01, 2'b10, 2'b11, 2'b00, 2'b10 → o_data=10'h239 after the 5th beat. A back-to-back second word follows with no idle cycle.
- Backpressure: hold i_ready=0 with word 0x34D pending and stream the next word.
  - 9 beats are accepted; o_ready=0 at the 10th; o_data stays 0x34D.
  - Raising i_ready accepts the 10th beat in that same cycle, and the new word appears on the next cycle.
- Flush: after 4 beats assert i_flush, then send 10 beats of 0x2AA pattern → o_data=10'h2AA with no residue from the flushed beats.
- Flush coincident with last beat: no o_valid, count=0, and the next full word is correct.
